// File: rtl/com_op_code_w_sequencer.sv
// Command sequencer in front of the test-number decoder.
// Decodes single-cycle command writes into a reset pulse, an execute level
// and a latched test number, and tracks the run lifecycle (done, abort,
// watchdog timeout) with sticky status flags for the register bank.
module com_op_code_w_sequencer #(
    parameter int unsigned                 RESET_CYCLES   = 4,
    parameter int unsigned                 TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0]        TIMEOUT_CYCLES = 24'hFF_FFFF,
    parameter int unsigned                 TEST_MAX       = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_wr_en,
    input  logic [31:0] cmd_wr_data,
    input  logic        test_done,
    output logic        op_code_w_reset,
    output logic        op_code_w_execute,
    output logic [3:0]  test_number,
    output logic        busy,
    output logic        done_pulse,
    output logic [7:0]  status
);

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_RESET = 4'd1;
    localparam logic [3:0] OP_EXEC  = 4'd2;
    localparam logic [3:0] OP_ABORT = 4'd3;
    localparam logic [3:0] OP_CLEAR = 4'd4;

    localparam int unsigned CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);
    localparam logic WDOG_EN = (TIMEOUT_CYCLES != {TIMEOUT_W{1'b0}});

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    // A test number is runnable only inside 1..TEST_MAX.
    function automatic logic test_ok(input logic [3:0] tn);
        return (tn != 4'd0) && ({28'd0, tn} <= TEST_MAX);
    endfunction

    state_t               state_r, state_s;
    logic [CNT_W-1:0]     rst_cnt_r, rst_cnt_s;
    logic [TIMEOUT_W-1:0] wdog_r, wdog_s;
    logic [3:0]           test_number_r, test_number_s;
    logic                 done_flag_r, done_flag_s;
    logic                 cmd_err_r, cmd_err_s;
    logic                 timeout_r, timeout_s;
    logic                 reset_out_r, exec_out_r, busy_r, done_pulse_r, done_pulse_s;
    logic [3:0]           op_s;
    logic [3:0]           tn_s;
    logic                 cmd_unused_s;

    assign op_s         = cmd_wr_data[3:0];
    assign tn_s         = cmd_wr_data[7:4];
    assign cmd_unused_s = ^cmd_wr_data[31:8];

    // Next-state, counters and sticky flags for the run lifecycle.
    always_comb begin
        state_s       = state_r;
        rst_cnt_s     = rst_cnt_r;
        wdog_s        = wdog_r;
        test_number_s = test_number_r;
        done_flag_s   = done_flag_r;
        cmd_err_s     = cmd_err_r;
        timeout_s     = timeout_r;
        done_pulse_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_wr_en) begin
                    case (op_s)
                        OP_NOP, OP_ABORT: begin
                            state_s = ST_IDLE;
                        end
                        OP_RESET: begin
                            state_s     = ST_RST;
                            rst_cnt_s   = RST_LOAD;
                            done_flag_s = 1'b0;
                            cmd_err_s   = 1'b0;
                            timeout_s   = 1'b0;
                        end
                        OP_EXEC: begin
                            if (test_ok(tn_s)) begin
                                state_s       = ST_EXEC;
                                test_number_s = tn_s;
                                wdog_s        = {TIMEOUT_W{1'b0}};
                                done_flag_s   = 1'b0;
                                timeout_s     = 1'b0;
                            end else begin
                                cmd_err_s = 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            done_flag_s = 1'b0;
                            cmd_err_s   = 1'b0;
                            timeout_s   = 1'b0;
                        end
                        default: begin
                            cmd_err_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RST: begin
                if (cmd_wr_en && (op_s == OP_RESET)) begin
                    rst_cnt_s = RST_LOAD;
                end else begin
                    if (cmd_wr_en) begin
                        cmd_err_s = 1'b1;
                    end else begin
                        cmd_err_s = cmd_err_r;
                    end
                    if (rst_cnt_r == {CNT_W{1'b0}}) begin
                        state_s = ST_IDLE;
                    end else begin
                        rst_cnt_s = rst_cnt_r - CNT_W'(1);
                    end
                end
            end
            ST_EXEC: begin
                // Watchdog saturates instead of wrapping.
                if (wdog_r != {TIMEOUT_W{1'b1}}) begin
                    wdog_s = wdog_r + TIMEOUT_W'(1);
                end else begin
                    wdog_s = wdog_r;
                end
                if (cmd_wr_en) begin
                    case (op_s)
                        OP_NOP, OP_RESET, OP_ABORT: begin
                            cmd_err_s = cmd_err_r;
                        end
                        OP_CLEAR: begin
                            done_flag_s = 1'b0;
                            cmd_err_s   = 1'b0;
                            timeout_s   = 1'b0;
                        end
                        default: begin
                            cmd_err_s = 1'b1;
                        end
                    endcase
                end else begin
                    cmd_err_s = cmd_err_r;
                end
                // Exit priority: RESET, ABORT, test_done, watchdog.
                if (cmd_wr_en && (op_s == OP_RESET)) begin
                    state_s     = ST_RST;
                    rst_cnt_s   = RST_LOAD;
                    done_flag_s = 1'b0;
                    cmd_err_s   = 1'b0;
                    timeout_s   = 1'b0;
                end else if (cmd_wr_en && (op_s == OP_ABORT)) begin
                    state_s = ST_IDLE;
                end else if (test_done) begin
                    state_s      = ST_IDLE;
                    done_pulse_s = 1'b1;
                    done_flag_s  = 1'b1;
                end else if (WDOG_EN && (wdog_r == WDOG_LAST)) begin
                    state_s   = ST_IDLE;
                    timeout_s = 1'b1;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counters, flags and registered decoder outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            rst_cnt_r     <= {CNT_W{1'b0}};
            wdog_r        <= {TIMEOUT_W{1'b0}};
            test_number_r <= 4'd0;
            done_flag_r   <= 1'b0;
            cmd_err_r     <= 1'b0;
            timeout_r     <= 1'b0;
            reset_out_r   <= 1'b0;
            exec_out_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_pulse_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            rst_cnt_r     <= rst_cnt_s;
            wdog_r        <= wdog_s;
            test_number_r <= test_number_s;
            done_flag_r   <= done_flag_s;
            cmd_err_r     <= cmd_err_s;
            timeout_r     <= timeout_s;
            reset_out_r   <= (state_s == ST_RST);
            exec_out_r    <= (state_s == ST_EXEC);
            busy_r        <= (state_s == ST_RST) || (state_s == ST_EXEC);
            done_pulse_r  <= done_pulse_s;
        end
    end

    assign op_code_w_reset   = reset_out_r;
    assign op_code_w_execute = exec_out_r;
    assign test_number       = test_number_r;
    assign busy              = busy_r;
    assign done_pulse        = done_pulse_r;
    assign status            = {4'b0000, timeout_r, cmd_err_r, done_flag_r, busy_r};

endmodule

// File: tb/tb_com_op_code_w_sequencer.sv
// Directed bench for com_op_code_w_sequencer (watchdog shortened to 16 cycles).
module tb_com_op_code_w_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_wr_en;
    logic [31:0] cmd_wr_data;
    logic        test_done;
    logic        op_code_w_reset;
    logic        op_code_w_execute;
    logic [3:0]  test_number;
    logic        busy;
    logic        done_pulse;
    logic [7:0]  status;

    int total = 0;
    int bad   = 0;

    com_op_code_w_sequencer #(
        .RESET_CYCLES  (4),
        .TIMEOUT_W     (24),
        .TIMEOUT_CYCLES(24'd16),
        .TEST_MAX      (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_wr_en        (cmd_wr_en),
        .cmd_wr_data      (cmd_wr_data),
        .test_done        (test_done),
        .op_code_w_reset  (op_code_w_reset),
        .op_code_w_execute(op_code_w_execute),
        .test_number      (test_number),
        .busy             (busy),
        .done_pulse       (done_pulse),
        .status           (status)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one command for a single cycle; returns in cycle N+1.
    task automatic write_cmd(input logic [31:0] data);
        cmd_wr_en   = 1'b1;
        cmd_wr_data = data;
        cyc();
        cmd_wr_en   = 1'b0;
        cmd_wr_data = 32'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        total++;
        if ({op_code_w_reset, op_code_w_execute, busy, done_pulse} !== 4'b0000) begin
            $display("FAIL reset_ctrl got=%b want=0000", {op_code_w_reset, op_code_w_execute, busy, done_pulse});
            bad++;
        end
        total++;
        if (test_number !== 4'd0) begin
            $display("FAIL reset_tn got=%0d want=0", test_number);
            bad++;
        end
        total++;
        if (status !== 8'h00) begin
            $display("FAIL reset_status got=%h want=00", status);
            bad++;
        end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_execute_done();
        write_cmd(32'h0000_0012);
        total++;
        if ({op_code_w_execute, busy, test_number} !== {1'b1, 1'b1, 4'd1}) begin
            $display("FAIL exec_start got exe=%b busy=%b tn=%0d want 1 1 1", op_code_w_execute, busy, test_number);
            bad++;
        end
        total++;
        if (status !== 8'h01) begin
            $display("FAIL exec_status got=%h want=01", status);
            bad++;
        end
        for (int i = 0; i < 9; i++) begin
            cyc();
            total++;
            if (op_code_w_execute !== 1'b1) begin
                $display("FAIL exec_hold cyc=%0d got=%b want=1", i, op_code_w_execute);
                bad++;
            end
        end
        test_done = 1'b1;
        cyc();
        test_done = 1'b0;
        total++;
        if ({op_code_w_execute, done_pulse, status} !== {1'b0, 1'b1, 8'h02}) begin
            $display("FAIL done_exit got exe=%b pulse=%b st=%h want 0 1 02", op_code_w_execute, done_pulse, status);
            bad++;
        end
        cyc();
        total++;
        if ({done_pulse, status} !== {1'b0, 8'h02}) begin
            $display("FAIL done_one_shot got pulse=%b st=%h want 0 02", done_pulse, status);
            bad++;
        end
        // test_done outside EXEC must be ignored.
        test_done = 1'b1;
        cyc();
        test_done = 1'b0;
        total++;
        if ({done_pulse, op_code_w_execute, status} !== {1'b0, 1'b0, 8'h02}) begin
            $display("FAIL done_idle got pulse=%b exe=%b st=%h want 0 0 02", done_pulse, op_code_w_execute, status);
            bad++;
        end
    endtask

    task automatic test_reset_cmd();
        int hi = 0;
        write_cmd(32'h0000_0001);
        total++;
        if (op_code_w_reset !== 1'b1) begin
            $display("FAIL rst_start got=%b want=1", op_code_w_reset);
            bad++;
        end
        for (int i = 0; i < 8; i++) begin
            if (op_code_w_reset === 1'b1) begin
                hi++;
                total++;
                if ({busy, op_code_w_execute} !== 2'b10) begin
                    $display("FAIL rst_busy got=%b want=10", {busy, op_code_w_execute});
                    bad++;
                end
            end
            cyc();
        end
        total++;
        if (hi != 4) begin
            $display("FAIL rst_len got=%0d want=4", hi);
            bad++;
        end
        total++;
        if ({busy, status} !== {1'b0, 8'h00}) begin
            $display("FAIL rst_after got busy=%b st=%h want 0 00", busy, status);
            bad++;
        end
    endtask

    task automatic test_bad_exec();
        write_cmd(32'h0000_0052);
        total++;
        if ({op_code_w_execute, busy, status, test_number} !== {1'b0, 1'b0, 8'h04, 4'd1}) begin
            $display("FAIL exec_tn5 got exe=%b busy=%b st=%h tn=%0d want 0 0 04 1", op_code_w_execute, busy, status, test_number);
            bad++;
        end
        write_cmd(32'h0000_0002);
        total++;
        if ({op_code_w_execute, status, test_number} !== {1'b0, 8'h04, 4'd1}) begin
            $display("FAIL exec_tn0 got exe=%b st=%h tn=%0d want 0 04 1", op_code_w_execute, status, test_number);
            bad++;
        end
        write_cmd(32'h0000_0004);
        total++;
        if (status !== 8'h00) begin
            $display("FAIL clear_status got=%h want=00", status);
            bad++;
        end
        write_cmd(32'hFFFF_FF0F);
        total++;
        if ({busy, status} !== {1'b0, 8'h04}) begin
            $display("FAIL illegal_op got busy=%b st=%h want 0 04", busy, status);
            bad++;
        end
        write_cmd(32'h0000_0004);
    endtask

    task automatic test_timeout();
        int hi = 0;
        int pulses = 0;
        write_cmd(32'h0000_0032);
        for (int i = 0; i < 30; i++) begin
            if (op_code_w_execute === 1'b1) hi++;
            if (done_pulse === 1'b1) pulses++;
            cyc();
        end
        total++;
        if (hi != 16) begin
            $display("FAIL timeout_len got=%0d want=16", hi);
            bad++;
        end
        total++;
        if ({status, test_number} !== {8'h08, 4'd3}) begin
            $display("FAIL timeout_status got st=%h tn=%0d want 08 3", status, test_number);
            bad++;
        end
        total++;
        if (pulses != 0) begin
            $display("FAIL timeout_pulse got=%0d want=0", pulses);
            bad++;
        end
    endtask

    task automatic test_abort_and_dup();
        write_cmd(32'h0000_0022);
        total++;
        if ({op_code_w_execute, test_number, status} !== {1'b1, 4'd2, 8'h01}) begin
            $display("FAIL abort_setup got exe=%b tn=%0d st=%h want 1 2 01", op_code_w_execute, test_number, status);
            bad++;
        end
        cmd_wr_en   = 1'b1;
        cmd_wr_data = 32'h0000_0003;
        test_done   = 1'b1;
        cyc();
        cmd_wr_en   = 1'b0;
        test_done   = 1'b0;
        total++;
        if ({op_code_w_execute, done_pulse, status} !== {1'b0, 1'b0, 8'h00}) begin
            $display("FAIL abort_vs_done got exe=%b pulse=%b st=%h want 0 0 00", op_code_w_execute, done_pulse, status);
            bad++;
        end
        write_cmd(32'h0000_0022);
        write_cmd(32'h0000_0042);
        total++;
        if ({op_code_w_execute, test_number, status} !== {1'b1, 4'd2, 8'h05}) begin
            $display("FAIL dup_exec got exe=%b tn=%0d st=%h want 1 2 05", op_code_w_execute, test_number, status);
            bad++;
        end
        write_cmd(32'h0000_0003);
        total++;
        if ({op_code_w_execute, test_number, status} !== {1'b0, 4'd2, 8'h04}) begin
            $display("FAIL dup_abort got exe=%b tn=%0d st=%h want 0 2 04", op_code_w_execute, test_number, status);
            bad++;
        end
    endtask

    task automatic test_async_reset();
        write_cmd(32'h0000_0032);
        total++;
        if ({op_code_w_execute, status} !== {1'b1, 8'h05}) begin
            $display("FAIL async_setup got exe=%b st=%h want 1 05", op_code_w_execute, status);
            bad++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({op_code_w_execute, busy, done_pulse, status, test_number} !== {1'b0, 1'b0, 1'b0, 8'h00, 4'd0}) begin
            $display("FAIL async_drop got exe=%b busy=%b pulse=%b st=%h tn=%0d want 0 0 0 00 0", op_code_w_execute, busy, done_pulse, status, test_number);
            bad++;
        end
        cyc();
        reset_n = 1'b1;
        test_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if ({op_code_w_reset, op_code_w_execute, busy, done_pulse, status} !== {4'b0000, 8'h00}) begin
                $display("FAIL async_after cyc=%0d got rst=%b exe=%b busy=%b pulse=%b st=%h want all 0", i, op_code_w_reset, op_code_w_execute, busy, done_pulse, status);
                bad++;
            end
        end
        test_done = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b0;
        cmd_wr_en   = 1'b0;
        cmd_wr_data = 32'd0;
        test_done   = 1'b0;
        test_reset();
        test_execute_done();
        test_reset_cmd();
        test_bad_exec();
        test_timeout();
        test_abort_and_dup();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
